trail_ram_arbiter: RTL and testbench
====================================

Name: trail_ram_arbiter

Overview:
- Owns the single write port of the trail frame RAM.
- Shares that port between two player write requesters (player 1 and player 2 trail writers) using round-robin arbitration.
- Runs a full-RAM clear sweep on request, used for game restart.
- Sits between the player modules and the RAM write port, all in the CLOCK_50 domain; the VGA read port is untouched.

Parameters:
- ADDR_W, 19, RAM address width.
- DATA_W, 8, RAM data width (trail code).
- NUM_PIXELS, 307200, number of addressable pixels (640x480); the clear sweep covers 0..NUM_PIXELS-1.
- CLEAR_VALUE, 0, data written during the clear sweep.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high.
- clear_req  in  1  level; sampled only in IDLE.
- clear_busy  out  1  high while the sweep is running.
- p1_req  in  1  player 1 write request.
- p1_addr  in  ADDR_W  player 1 write address.
- p1_data  in  DATA_W  player 1 write data.
- p1_gnt  out  1  one-cycle grant pulse for player 1.
- p2_req  in  1  player 2 write request.
- p2_addr  in  ADDR_W  player 2 write address.
- p2_data  in  DATA_W  player 2 write data.
- p2_gnt  out  1  one-cycle grant pulse for player 2.
- wr_addr  out  ADDR_W  registered RAM write address.
- wr_data  out  DATA_W  registered RAM write data.
- wren  out  1  registered RAM write enable.

Behaviour:
- Reset: clock is CLOCK_50; reset is synchronous, active-high.
  - On reset: state=IDLE, wren=0, wr_addr=0, wr_data=0, p1_gnt=p2_gnt=0, clear_busy=0, clr_cnt=0, last_grant=P2 (so P1 wins the first tie).
- States: IDLE (player arbitration) and CLEAR.
- IDLE, one-cycle latency:
  - Request inputs are sampled at edge N.
  - At edge N+1 these are registered: wren=1, wr_addr/wr_data of the winner, and winner gnt=1 for exactly one cycle.
- Requester handshake:
  - The requester holds req/addr/data stable until it sees gnt, then must drop req or present a new write.
  - The arbiter ignores a requester's req during the cycle its gnt is high. Each requester therefore gets at most one write every 2 cycles, with no double-write.
- Round-robin:
  - If only one eligible requester, it wins.
  - If both are eligible, the one not equal to last_grant wins, and last_grant updates.
- No eligible request: wren=0, both gnt=0; wr_addr and wr_data hold their values.
- Out-of-range player address (addr >= NUM_PIXELS): gnt is still pulsed, wren is forced to 0 (the write is dropped).
- Entering CLEAR: clear_req=1 in IDLE moves to CLEAR at the next edge; clear_busy=1 from that edge.
  - clear_req has priority over simultaneous player requests; no gnt is issued in that cycle.
- CLEAR sweep:
  - Every cycle: wren=1, wr_addr=clr_cnt, wr_data=CLEAR_VALUE, clr_cnt+1.
  - Sweep takes exactly NUM_PIXELS cycles.
  - After the write to NUM_PIXELS-1: next edge goes to IDLE, clear_busy=0, clr_cnt=0, wren=0.
- During CLEAR: player requests are never granted (requesters stall, holding req); clear_req is ignored.
- Reset mid-CLEAR: the sweep aborts immediately with all reset values. RAM contents are undefined; the top level must re-issue clear_req.
- clear_req held high after the sweep completes: a new sweep starts on the next IDLE cycle (level-sensitive). The top level uses a pulse.
- Width rules: clr_cnt is ADDR_W bits. The terminal compare is clr_cnt==NUM_PIXELS-1; no wrap through 2^ADDR_W.

Optional Feature:
- Macro: TRAIL_ARB_AUTOCLEAR_ON_RESET_EN.
- Defined: on the first edge with reset deasserted, the FSM enters CLEAR automatically (same as clear_req=1), so the RAM is blank after power-up or reset without top-level action.
- Undefined: after reset the FSM stays in IDLE until clear_req.

Decomposition:
- Package trail_pkg holds:
  - SCREEN_W=640, SCREEN_H=480, NUM_PIXELS, ADDR_W, DATA_W;
  - trail codes PLAYER1_CODE=8'h01, PLAYER2_CODE=8'h80, CLEAR_VALUE=8'h00;
  - the state enum {IDLE, CLEAR}.
- Sub-module rr_arbiter2: two-requester round-robin with last_grant register; inputs are eligible requests, output is a one-hot winner.
- The top FSM, clear counter and output registers stay in trail_ram_arbiter.

Test Plan:
- Reset, then p1_req=1 with addr=154056, data=8'h01 -> one cycle later wren=1, wr_addr=154056, wr_data=8'h01, p1_gnt=1 for exactly 1 cycle; no second write while gnt is high.
- p1_req and p2_req high together, held continuously -> grants alternate P1,P2,P1,P2; wr_data alternates 8'h01/8'h80; no cycle has both gnt high.
- NUM_PIXELS=16, clear_req pulse -> clear_busy high 16 cycles; wr_addr 0..15 with wren=1 and wr_data=0; IDLE afterwards; p1_req pending throughout is granted only after the sweep.
- NUM_PIXELS=16, reset asserted at sweep address 7 -> next cycle wren=0, clear_busy=0, state IDLE; a new clear_req restarts the sweep at address 0.
- p2_req with addr=307200 -> p2_gnt=1 and wren=0.
- With TRAIL_ARB_AUTOCLEAR_ON_RESET_EN defined -> clear_busy rises on the first cycle after reset deasserts, with no clear_req.

Source files
------------

// File: rtl/trail_ram_arbiter_pkg.sv
// Shared definitions for the trail frame RAM write path:
// screen geometry, RAM widths, trail codes and the arbiter state encoding.
package trail_pkg;

    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int NUM_PIXELS = SCREEN_W * SCREEN_H;
    localparam int ADDR_W     = 19;
    localparam int DATA_W     = 8;

    localparam logic [7:0] PLAYER1_CODE = 8'h01;
    localparam logic [7:0] PLAYER2_CODE = 8'h80;
    localparam logic [7:0] CLEAR_VALUE  = 8'h00;

    // Bit positions of the two requesters in request/winner vectors.
    localparam int RR_P1 = 0;
    localparam int RR_P2 = 1;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/trail_ram_arbiter_rr_arbiter2.sv
// Two-requester round-robin arbiter. The winner is combinational and one-hot.
// last_grant only advances when the owner commits the grant (i_update),
// so an arbitration cycle that is overridden (e.g. by a clear) does not
// disturb fairness. Reset leaves last_grant at P2 so P1 wins the first tie.
module rr_arbiter2
    import trail_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [1:0] i_req,
    input  logic       i_update,
    output logic [1:0] o_win
);

    logic r_last_p2;

    // Pick the single requester, or on a tie the one that did not win last.
    always_comb begin
        o_win = 2'b00;
        if (i_req == 2'b11) begin
            o_win = r_last_p2 ? 2'b01 : 2'b10;
        end else begin
            o_win = i_req;
        end
    end

    // Remember who was granted last so ties alternate.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_last_p2 <= 1'b1;
        end else if (i_update && (o_win != 2'b00)) begin
            r_last_p2 <= o_win[RR_P2];
        end
    end

endmodule

// File: rtl/trail_ram_arbiter.sv
// Trail frame RAM write-port owner: round-robin sharing between the two
// player trail writers plus a full-RAM clear sweep for game restart.
// Optional build macro TRAIL_ARB_AUTOCLEAR_ON_RESET_EN: start a clear sweep
// automatically on the first edge after reset is released.
//
// Handshake: a requester raises pX_req with pX_addr/pX_data stable and
// holds them until it sees pX_gnt (a one-cycle pulse issued together with
// the registered write). During the cycle pX_gnt is high the arbiter ignores
// pX_req, so the requester may drop req or present its next write then.
module trail_ram_arbiter
    import trail_pkg::*;
#(
    parameter int                ADDR_W      = trail_pkg::ADDR_W,
    parameter int                DATA_W      = trail_pkg::DATA_W,
    parameter int                NUM_PIXELS  = trail_pkg::NUM_PIXELS,
    parameter logic [DATA_W-1:0] CLEAR_VALUE = trail_pkg::CLEAR_VALUE
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              clear_req,
    output logic              clear_busy,
    input  logic              p1_req,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_data,
    output logic              p1_gnt,
    input  logic              p2_req,
    input  logic [ADDR_W-1:0] p2_addr,
    input  logic [DATA_W-1:0] p2_data,
    output logic              p2_gnt,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wren,
    output state_t            o_dbg_state
);

    // Last valid pixel address; the sweep stops here and never wraps.
    localparam logic [ADDR_W-1:0] LP_LAST = ADDR_W'(NUM_PIXELS - 1);

    state_t              r_state;
    state_t              w_state_n;
    logic [ADDR_W-1:0]   r_clr_cnt, w_clr_cnt_n;
    logic [ADDR_W-1:0]   r_wr_addr, w_wr_addr_n;
    logic [DATA_W-1:0]   r_wr_data, w_wr_data_n;
    logic                r_wren, w_wren_n;
    logic                r_p1_gnt, w_p1_gnt_n;
    logic                r_p2_gnt, w_p2_gnt_n;
    logic                r_clear_busy, w_clear_busy_n;
    logic                w_clear_start;
    logic                w_clr_last;
    logic                w_arb_update;
    logic [1:0]          w_elig;
    logic [1:0]          w_win;
    logic                w_p1_in_range;
    logic                w_p2_in_range;

`ifdef TRAIL_ARB_AUTOCLEAR_ON_RESET_EN
    logic r_boot_clear;

    // Flag that stays set through reset so the first free edge starts a sweep.
    always_ff @(posedge CLOCK_50) begin
        r_boot_clear <= reset;
    end

    assign w_clear_start = clear_req | r_boot_clear;
`else
    assign w_clear_start = clear_req;
`endif

    assign w_clr_last    = (r_clr_cnt == LP_LAST);
    assign w_p1_in_range = (p1_addr <= LP_LAST);
    assign w_p2_in_range = (p2_addr <= LP_LAST);
    // A requester whose grant is showing this cycle is not eligible again yet.
    assign w_elig        = {p2_req & ~r_p2_gnt, p1_req & ~r_p1_gnt};
    assign w_arb_update  = (r_state == IDLE) && !w_clear_start;

    rr_arbiter2 u_rr (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .i_req    (w_elig),
        .i_update (w_arb_update),
        .o_win    (w_win)
    );

    // State register plus all registered outputs and the clear counter.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state      <= IDLE;
            r_clr_cnt    <= '0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_wren       <= 1'b0;
            r_p1_gnt     <= 1'b0;
            r_p2_gnt     <= 1'b0;
            r_clear_busy <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_clr_cnt    <= w_clr_cnt_n;
            r_wr_addr    <= w_wr_addr_n;
            r_wr_data    <= w_wr_data_n;
            r_wren       <= w_wren_n;
            r_p1_gnt     <= w_p1_gnt_n;
            r_p2_gnt     <= w_p2_gnt_n;
            r_clear_busy <= w_clear_busy_n;
        end
    end

    // Next state: clear request wins over arbitration; sweep ends on last pixel.
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE:    if (w_clear_start) w_state_n = CLEAR;
            CLEAR:   if (w_clr_last)    w_state_n = IDLE;
            default: w_state_n = IDLE;
        endcase
    end

    // Next register values: player write, clear write, or hold address/data.
    always_comb begin
        w_wren_n       = 1'b0;
        w_wr_addr_n    = r_wr_addr;
        w_wr_data_n    = r_wr_data;
        w_p1_gnt_n     = 1'b0;
        w_p2_gnt_n     = 1'b0;
        w_clear_busy_n = 1'b0;
        w_clr_cnt_n    = '0;
        case (r_state)
            IDLE: begin
                if (w_clear_start) begin
                    w_clear_busy_n = 1'b1;
                end else if (w_win[RR_P1]) begin
                    w_p1_gnt_n  = 1'b1;
                    w_wr_addr_n = p1_addr;
                    w_wr_data_n = p1_data;
                    w_wren_n    = w_p1_in_range;
                end else if (w_win[RR_P2]) begin
                    w_p2_gnt_n  = 1'b1;
                    w_wr_addr_n = p2_addr;
                    w_wr_data_n = p2_data;
                    w_wren_n    = w_p2_in_range;
                end
            end
            CLEAR: begin
                w_wren_n    = 1'b1;
                w_wr_addr_n = r_clr_cnt;
                w_wr_data_n = CLEAR_VALUE;
                if (!w_clr_last) begin
                    w_clear_busy_n = 1'b1;
                    w_clr_cnt_n    = r_clr_cnt + 1'b1;
                end
            end
            default: begin
                w_wren_n = 1'b0;
            end
        endcase
    end

    assign clear_busy  = r_clear_busy;
    assign p1_gnt      = r_p1_gnt;
    assign p2_gnt      = r_p2_gnt;
    assign wr_addr     = r_wr_addr;
    assign wr_data     = r_wr_data;
    assign wren        = r_wren;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_trail_ram_arbiter.sv
// Directed bench for trail_ram_arbiter. Two instances share the player
// inputs and reset: "b" uses the full 640x480 screen, "s" a 16-pixel screen
// so the clear sweep is short. Each has its own clear_req.
module tb_trail_ram_arbiter;
    import trail_pkg::*;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        clr_b, clr_s;
    logic        p1_req, p2_req;
    logic [18:0] p1_addr, p2_addr;
    logic [7:0]  p1_data, p2_data;

    logic        b_busy, b_p1_gnt, b_p2_gnt, b_wren;
    logic [18:0] b_addr;
    logic [7:0]  b_data;
    state_t      b_state;
    logic        s_busy, s_p1_gnt, s_p2_gnt, s_wren;
    logic [18:0] s_addr;
    logic [7:0]  s_data;
    state_t      s_state;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock / reset ----------------
    always #10 CLOCK_50 = ~CLOCK_50;

    trail_ram_arbiter dut_b (
        .CLOCK_50 (CLOCK_50), .reset (reset), .clear_req (clr_b), .clear_busy (b_busy),
        .p1_req (p1_req), .p1_addr (p1_addr), .p1_data (p1_data), .p1_gnt (b_p1_gnt),
        .p2_req (p2_req), .p2_addr (p2_addr), .p2_data (p2_data), .p2_gnt (b_p2_gnt),
        .wr_addr (b_addr), .wr_data (b_data), .wren (b_wren), .o_dbg_state (b_state)
    );

    trail_ram_arbiter #(.NUM_PIXELS(16)) dut_s (
        .CLOCK_50 (CLOCK_50), .reset (reset), .clear_req (clr_s), .clear_busy (s_busy),
        .p1_req (p1_req), .p1_addr (p1_addr), .p1_data (p1_data), .p1_gnt (s_p1_gnt),
        .p2_req (p2_req), .p2_addr (p2_addr), .p2_data (p2_data), .p2_gnt (s_p2_gnt),
        .wr_addr (s_addr), .wr_data (s_data), .wren (s_wren), .o_dbg_state (s_state)
    );

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic drive_p1(input logic req, input logic [18:0] addr, input logic [7:0] data);
        p1_req  = req;
        p1_addr = addr;
        p1_data = data;
    endtask

    task automatic drive_p2(input logic req, input logic [18:0] addr, input logic [7:0] data);
        p2_req  = req;
        p2_addr = addr;
        p2_data = data;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] exp_g1;
        reset = 1'b1;
        clr_b = 1'b0;
        clr_s = 1'b0;
        drive_p1(1'b0, '0, '0);
        drive_p2(1'b0, '0, '0);
        repeat (3) step();

        // Reset state
        check("rst_wren",  32'(b_wren), 0);
        check("rst_addr",  32'(b_addr), 0);
        check("rst_data",  32'(b_data), 0);
        check("rst_p1gnt", 32'(b_p1_gnt), 0);
        check("rst_p2gnt", 32'(b_p2_gnt), 0);
        check("rst_busy",  32'(b_busy), 0);
        check("rst_state", 32'(s_state), 32'(IDLE));

        reset = 1'b0;
        step();

`ifdef TRAIL_ARB_AUTOCLEAR_ON_RESET_EN
        // Sweep starts by itself on the first edge after reset release.
        check("auto_busy_s",  32'(s_busy), 1);
        check("auto_state_s", 32'(s_state), 32'(CLEAR));
        check("auto_busy_b",  32'(b_busy), 1);
        repeat (17) step();
        check("auto_done_s",  32'(s_busy), 0);
        check("auto_idle_s",  32'(s_state), 32'(IDLE));
`else
        check("no_autoclear_busy", 32'(s_busy), 0);
        check("no_autoclear_st",   32'(s_state), 32'(IDLE));

        // Both requesters held: P1 wins first tie, then strict alternation.
        drive_p1(1'b1, 19'd100, PLAYER1_CODE);
        drive_p2(1'b1, 19'd200, PLAYER2_CODE);
        exp_g1 = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("alt_p1gnt[%0d]", i), 32'(b_p1_gnt), 32'(exp_g1[i]));
            check($sformatf("alt_p2gnt[%0d]", i), 32'(b_p2_gnt), 32'(!exp_g1[i]));
            check($sformatf("alt_data[%0d]", i),  32'(b_data), exp_g1[i] ? 32'h01 : 32'h80);
            check($sformatf("alt_addr[%0d]", i),  32'(b_addr), exp_g1[i] ? 32'd100 : 32'd200);
            check($sformatf("alt_wren[%0d]", i),  32'(b_wren), 1);
        end
        drive_p1(1'b0, '0, '0);
        drive_p2(1'b0, '0, '0);
        step();
        check("alt_idle_wren", 32'(b_wren), 0);

        // Single P1 write, one-cycle latency, no double write while gnt high.
        drive_p1(1'b1, 19'd154056, PLAYER1_CODE);
        step();
        check("p1_wren",   32'(b_wren), 1);
        check("p1_addr",   32'(b_addr), 154056);
        check("p1_data",   32'(b_data), 32'h01);
        check("p1_gnt",    32'(b_p1_gnt), 1);
        check("p1_s_gnt",  32'(s_p1_gnt), 1);
        check("p1_s_oor",  32'(s_wren), 0);
        step();
        check("p1_gnt_one", 32'(b_p1_gnt), 0);
        check("p1_no_dbl",  32'(b_wren), 0);
        check("p1_hold_a",  32'(b_addr), 154056);
        check("p1_hold_d",  32'(b_data), 32'h01);
        drive_p1(1'b0, '0, '0);
        step();
        check("p1_quiet", 32'(b_wren), 0);

        // Out-of-range P2 address: grant pulses, write dropped.
        drive_p2(1'b1, 19'd307200, PLAYER2_CODE);
        step();
        check("oor_p2gnt", 32'(b_p2_gnt), 1);
        check("oor_wren",  32'(b_wren), 0);
        drive_p2(1'b0, '0, '0);
        step();

        // Clear sweep on 16 pixels with P1 pending throughout.
        clr_s = 1'b1;
        drive_p1(1'b1, 19'd3, PLAYER1_CODE);
        step();
        clr_s = 1'b0;
        check("clr_enter_busy",  32'(s_busy), 1);
        check("clr_enter_state", 32'(s_state), 32'(CLEAR));
        check("clr_enter_gnt",   32'(s_p1_gnt), 0);
        check("clr_enter_wren",  32'(s_wren), 0);
        for (int k = 0; k < 16; k++) begin
            step();
            check($sformatf("clr_wren[%0d]", k), 32'(s_wren), 1);
            check($sformatf("clr_addr[%0d]", k), 32'(s_addr), 32'(k));
            check($sformatf("clr_data[%0d]", k), 32'(s_data), 0);
            check($sformatf("clr_gnt[%0d]", k),  32'(s_p1_gnt), 0);
            check($sformatf("clr_busy[%0d]", k), 32'(s_busy), (k < 15) ? 1 : 0);
        end
        check("clr_exit_state", 32'(s_state), 32'(IDLE));
        step();
        check("post_clr_gnt",  32'(s_p1_gnt), 1);
        check("post_clr_wren", 32'(s_wren), 1);
        check("post_clr_addr", 32'(s_addr), 3);
        check("post_clr_data", 32'(s_data), 32'h01);
        drive_p1(1'b0, '0, '0);
        step();

        // Reset in the middle of a sweep, then restart from address 0.
        clr_s = 1'b1;
        step();
        clr_s = 1'b0;
        repeat (8) step();
        check("mid_addr7", 32'(s_addr), 7);
        reset = 1'b1;
        step();
        check("abort_wren",  32'(s_wren), 0);
        check("abort_busy",  32'(s_busy), 0);
        check("abort_state", 32'(s_state), 32'(IDLE));
        check("abort_addr",  32'(s_addr), 0);
        reset = 1'b0;
        clr_s = 1'b1;
        drive_p1(1'b1, 19'd10, PLAYER1_CODE);
        drive_p2(1'b1, 19'd20, PLAYER2_CODE);
        step();
        clr_s = 1'b0;
        check("rst_tie_p1", 32'(b_p1_gnt), 1);
        check("rst_tie_p2", 32'(b_p2_gnt), 0);
        check("restart_busy", 32'(s_busy), 1);
        check("restart_nogt", 32'(s_p1_gnt), 0);
        drive_p1(1'b0, '0, '0);
        drive_p2(1'b0, '0, '0);
        step();
        check("restart_wren", 32'(s_wren), 1);
        check("restart_addr", 32'(s_addr), 0);
`endif

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
